// File: rtl/systolic_feeder.sv
// Systolic PE-chain feeder: FIFO-buffered sample words held for timing+1 clocks each, with slot/window strobes.
// Latency: a word pushed into an empty FIFO while IDLE reaches outputword two edges later; in RUN it waits for the next slot boundary.
// Backpressure: in_ready is low only while the FIFO is full; an empty FIFO at a slot start emits zero and sets underrun.

module systolic_feeder_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk30x,
    input  logic          reset_n,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    output logic          push_rdy,
    input  logic          pop_vld,
    output logic [W-1:0]  pop_dat,
    output logic [AW:0]   level
);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign push_rdy = (level != FULL_LVL);
    assign do_push  = push_vld && push_rdy;
    assign do_pop   = pop_vld && (level != '0);
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge clk30x) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk30x) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                level <= level + 1'b1;
            end else if (do_pop && !do_push) begin
                level <= level - 1'b1;
            end
        end
    end
endmodule

module systolic_feeder #(
    parameter int WORDLENGTH = 16,
    parameter int DEPTH      = 8,
    parameter int AW         = 3
) (
    input  logic                  clk30x,
    input  logic                  reset_n,
    input  logic [WORDLENGTH-1:0] in_word,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           timing,
    output logic [WORDLENGTH-1:0] outputword,
    output logic                  pe_reset,
    output logic                  word_strobe,
    output logic [2:0]            word_index,
    output logic                  window_done,
    output logic                  underrun,
    output logic [AW:0]           fifo_level
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t                state;
    logic [31:0]           cnt;
    logic [31:0]           tlat;
    logic [WORDLENGTH-1:0] head;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  slot_end;

    systolic_feeder_fifo #(
        .W     (WORDLENGTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk30x   (clk30x),
        .reset_n  (reset_n),
        .push_vld (in_valid),
        .push_dat (in_word),
        .push_rdy (in_ready),
        .pop_vld  (fifo_pop),
        .pop_dat  (head),
        .level    (fifo_level)
    );

    assign fifo_empty  = (fifo_level == '0);
    assign slot_end    = (state == RUN) && (cnt == tlat);
    assign fifo_pop    = ((state == PRIME) || slot_end) && !fifo_empty;
    assign window_done = slot_end && (word_index == 3'd7);

    // PRIME releases pe_reset one cycle before the first slot so the PE count steps -1 -> 0 in lock-step with cnt.
    always_ff @(posedge clk30x) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            tlat        <= '0;
            outputword  <= '0;
            pe_reset    <= 1'b1;
            word_strobe <= 1'b0;
            word_index  <= '0;
            underrun    <= 1'b0;
        end else begin
            word_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    pe_reset   <= 1'b1;
                    outputword <= '0;
                    if (!fifo_empty) begin
                        state    <= PRIME;
                        pe_reset <= 1'b0;
                    end
                end
                PRIME: begin
                    state       <= RUN;
                    outputword  <= head;
                    word_strobe <= 1'b1;
                    word_index  <= '0;
                    tlat        <= timing;
                    cnt         <= '0;
                end
                RUN: begin
                    if (slot_end) begin
                        cnt         <= '0;
                        word_index  <= word_index + 1'b1;
                        tlat        <= timing;
                        word_strobe <= 1'b1;
                        if (!fifo_empty) begin
                            outputword <= head;
                        end else begin
                            // PEs free-run, so the slot still advances with a zero word.
                            outputword <= '0;
                            underrun   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: reset, prime alignment, windows, underrun, timing changes, mid-run reset.
module tb_systolic_feeder;
    localparam int WL    = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk30x = 1'b0;
    logic          reset_n;
    logic [WL-1:0] in_word;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   timing;
    logic [WL-1:0] outputword;
    logic          pe_reset;
    logic          word_strobe;
    logic [2:0]    word_index;
    logic          window_done;
    logic          underrun;
    logic [AW:0]   fifo_level;

    int checks = 0;
    int errors = 0;

    systolic_feeder #(.WORDLENGTH(WL), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk30x      (clk30x),
        .reset_n     (reset_n),
        .in_word     (in_word),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .timing      (timing),
        .outputword  (outputword),
        .pe_reset    (pe_reset),
        .word_strobe (word_strobe),
        .word_index  (word_index),
        .window_done (window_done),
        .underrun    (underrun),
        .fifo_level  (fifo_level)
    );

    always #5 clk30x = ~clk30x;

    task automatic tick();
        @(posedge clk30x);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] t);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_word  = '0;
        timing   = t;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    // {outputword, pe_reset, word_strobe, word_index, window_done, underrun, fifo_level, in_ready}
    task automatic test_reset();
        logic [27:0] obs;
        logic [27:0] exp;
        reset_n  = 1'b0;
        in_valid = 1'b1;
        in_word  = 16'hABCD;
        timing   = 32'd4;
        exp = {16'h0000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            tick();
            obs = {outputword, pe_reset, word_strobe, word_index, window_done, underrun, fifo_level, in_ready};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset cyc=%0d got %h want %h", i, obs, exp);
            end
        end
        in_valid = 1'b0;
        reset_n  = 1'b1;
        tick();
        obs = {outputword, pe_reset, word_strobe, word_index, window_done, underrun, fifo_level, in_ready};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_release got %h want %h", obs, exp);
        end
    endtask

    // {outputword, pe_reset, word_strobe, word_index, underrun, fifo_level}
    task automatic test_prime();
        logic [25:0]   obs;
        logic [25:0]   exp;
        logic [WL-1:0] e_out;
        logic [2:0]    e_idx;
        logic [3:0]    e_lvl;
        do_reset(32'd4);
        in_valid = 1'b1;
        in_word  = 16'h0011;
        for (int k = 0; k <= 12; k++) begin
            tick();
            if (k == 0) in_valid = 1'b0;
            e_out = (k < 2) ? 16'h0000 : (k <= 6) ? 16'h0011 : (k <= 11) ? 16'h0022 : 16'h0000;
            e_idx = (k < 7) ? 3'd0 : (k < 12) ? 3'd1 : 3'd2;
            e_lvl = (k <= 1) ? 4'd1 : (k == 2) ? 4'd0 : (k <= 6) ? 4'd1 : 4'd0;
            exp = {e_out, (k == 0), (k == 2 || k == 7 || k == 12), e_idx, (k >= 12), e_lvl};
            obs = {outputword, pe_reset, word_strobe, word_index, underrun, fifo_level};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL prime k=%0d got %h want %h", k, obs, exp);
            end
            if (k == 2) begin
                in_valid = 1'b1;
                in_word  = 16'h0022;
            end
            if (k == 3) in_valid = 1'b0;
        end
    endtask

    // {outputword, word_strobe, word_index, window_done}
    task automatic test_window();
        logic [20:0]   obs;
        logic [20:0]   exp;
        logic [WL-1:0] n;
        logic          acc;
        do_reset(32'd2);
        in_valid = 1'b1;
        in_word  = 16'h0001;
        for (int k = 0; k <= 49; k++) begin
            acc = in_valid && in_ready;
            tick();
            n = (k >= 2) ? WL'((k + 1) / 3) : '0;
            exp = {n, (k >= 2 && (k % 3) == 2), (k >= 2) ? 3'(n - 1) : 3'd0,
                   ((k % 3) == 1 && (n == 16'd8 || n == 16'd16))};
            obs = {outputword, word_strobe, word_index, window_done};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL window k=%0d got %h want %h", k, obs, exp);
            end
            if (k == 9 || k == 10 || k == 11) begin
                checks++;
                if ({fifo_level, in_ready} !== {(k == 10) ? 4'd8 : 4'd7, (k != 10)}) begin
                    errors++;
                    $display("FAIL window_level k=%0d got lvl=%0d rdy=%0b want lvl=%0d rdy=%0b",
                             k, fifo_level, in_ready, (k == 10) ? 8 : 7, (k != 10));
                end
            end
            if (acc) begin
                if (in_word == 16'h0010) in_valid = 1'b0;
                else in_word = in_word + 16'h0001;
            end
        end
    endtask

    // {outputword, word_strobe, word_index, underrun}
    task automatic test_underrun();
        logic [20:0]   obs;
        logic [20:0]   exp;
        logic [WL-1:0] e_out;
        int            n;
        do_reset(32'd3);
        in_valid = 1'b1;
        in_word  = 16'h00A1;
        tick();
        in_word = 16'h00A2;
        tick();
        in_valid = 1'b0;
        for (int k = 2; k <= 17; k++) begin
            if (k > 2) tick();
            else tick();
            n = (k + 2) / 4;
            e_out = (n == 1) ? 16'h00A1 : (n == 2) ? 16'h00A2 : 16'h0000;
            exp = {e_out, ((k - 2) % 4 == 0), 3'(n - 1), (k >= 10)};
            obs = {outputword, word_strobe, word_index, underrun};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL underrun k=%0d got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_timing_change();
        logic [20:0]   obs;
        logic [20:0]   exp;
        logic [WL-1:0] e_out;
        logic [2:0]    e_idx;
        do_reset(32'd5);
        in_valid = 1'b1;
        in_word  = 16'h00B1;
        for (int k = 0; k <= 13; k++) begin
            tick();
            if (k == 0) in_word = 16'h00B2;
            if (k == 1) in_word = 16'h00B3;
            if (k == 2) in_valid = 1'b0;
            if (k == 4) timing = 32'd1;
            e_out = (k < 2) ? 16'h0000 : (k < 8) ? 16'h00B1 : (k < 10) ? 16'h00B2 :
                    (k < 12) ? 16'h00B3 : 16'h0000;
            e_idx = (k < 8) ? 3'd0 : (k < 10) ? 3'd1 : (k < 12) ? 3'd2 : 3'd3;
            exp = {e_out, (k == 2 || k == 8 || k == 10 || k == 12), e_idx, (k >= 12)};
            obs = {outputword, word_strobe, word_index, underrun};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL timing_change k=%0d got %h want %h", k, obs, exp);
            end
        end
    endtask

    // {outputword, word_strobe, word_index, window_done, underrun}
    task automatic test_timing_zero();
        logic [21:0]   obs;
        logic [21:0]   exp;
        logic [WL-1:0] e_out;
        do_reset(32'd0);
        in_valid = 1'b1;
        in_word  = 16'h0C01;
        for (int k = 0; k <= 10; k++) begin
            tick();
            if (k == 0) in_word = 16'h0C02;
            if (k == 1) in_word = 16'h0C03;
            if (k == 2) in_valid = 1'b0;
            e_out = (k == 2) ? 16'h0C01 : (k == 3) ? 16'h0C02 : (k == 4) ? 16'h0C03 : 16'h0000;
            exp = {e_out, (k >= 2), (k >= 2) ? 3'(k - 2) : 3'd0, (k == 9), (k >= 5)};
            obs = {outputword, word_strobe, word_index, window_done, underrun};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL timing_zero k=%0d got %h want %h", k, obs, exp);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [27:0] obs;
        logic [27:0] exp;
        do_reset(32'd7);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_word = WL'(16'h0D00 + i);
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if ({fifo_level, pe_reset, word_strobe, outputword} !== {4'd4, 1'b0, 1'b0, 16'h0D00}) begin
            errors++;
            $display("FAIL mid_reset_pre got lvl=%0d per=%0b stb=%0b out=%h want lvl=4 per=0 stb=0 out=0d00",
                     fifo_level, pe_reset, word_strobe, outputword);
        end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        exp = {16'h0000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b1};
        obs = {outputword, pe_reset, word_strobe, word_index, window_done, underrun, fifo_level, in_ready};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL mid_reset_clear got %h want %h", obs, exp);
        end
        in_valid = 1'b1;
        in_word  = 16'h0E01;
        tick();
        in_valid = 1'b0;
        checks++;
        if ({fifo_level, pe_reset, outputword} !== {4'd1, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL mid_reset_push got lvl=%0d per=%0b out=%h want lvl=1 per=1 out=0000",
                     fifo_level, pe_reset, outputword);
        end
        tick();
        checks++;
        if ({pe_reset, word_strobe, outputword} !== {1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL mid_reset_prime got per=%0b stb=%0b out=%h want per=0 stb=0 out=0000",
                     pe_reset, word_strobe, outputword);
        end
        tick();
        checks++;
        if ({outputword, word_strobe, word_index, fifo_level, underrun} !==
            {16'h0E01, 1'b1, 3'd0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL mid_reset_reprime got out=%h stb=%0b idx=%0d lvl=%0d und=%0b want out=0e01 stb=1 idx=0 lvl=0 und=0",
                     outputword, word_strobe, word_index, fifo_level, underrun);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_word  = '0;
        timing   = '0;
        test_reset();
        test_prime();
        test_window();
        test_underrun();
        test_timing_change();
        test_timing_zero();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Transmit-side sequencer for the systolic PE chain. Accepts non-uniform sample words from the upstream sampler through a valid/ready handshake and buffers them in a small FIFO.
- Drives the shared inputword/timing/reset lines of the PE array. Each word is held for exactly (timing+1) clk30x cycles, in lock-step with each PE's internal slot counter.
- Publishes the 0..7 word index and window strobes so the output collector knows when a PE's 8-tap sum is complete.

Parameters:
WORDLENGTH, 16, sample word width
DEPTH, 8, FIFO depth in words; power of 2, at least 2
AW, 3, log2(DEPTH)

Ports:
clk30x  in  1  system clock, single clock domain
reset_n  in  1  synchronous, active-low reset
in_word  in  WORDLENGTH  sample from upstream
in_valid  in  1  in_word valid
in_ready  out  1  FIFO can accept; equals !full
timing  in  32  slot length minus 1, in clocks
outputword  out  WORDLENGTH  word driven to PE inputword
pe_reset  out  1  active-high reset to all PEs
word_strobe  out  1  one-cycle pulse on the first cycle of each slot
word_index  out  3  index of the word currently presented; matches the PE wordIndex
window_done  out  1  one-cycle pulse on the last cycle of a slot with word_index==7
underrun  out  1  sticky; set when a slot starts with the FIFO empty
fifo_level  out  AW+1  words currently buffered

Behaviour:
- Reset (reset_n low at an edge):
  - FIFO emptied; state IDLE.
  - outputword=0, pe_reset=1, word_strobe=0, word_index=0, window_done=0, underrun=0, fifo_level=0, in_ready=1.
- FIFO write:
  - A word is accepted on an edge where in_valid and in_ready are both high.
  - Simultaneous push and pop while full is not possible, because in_ready is low when full.
  - Simultaneous push and pop while non-empty leaves the level unchanged.
  - Write and read pointers wrap modulo DEPTH.
- States: IDLE, PRIME, RUN.
- IDLE:
  - pe_reset=1, outputword holds 0.
  - Moves to PRIME at the first edge where fifo_level>=1. A word pushed at edge E is visible at E+1, so PRIME is entered at E+1.
- PRIME (exactly 1 cycle):
  - pe_reset=0. The head word is popped and driven on outputword.
  - word_strobe=1, word_index=0.
  - timing is latched into tlat; slot counter cnt=0.
  - Next state is RUN. This gives the PE one cycle to step from count=-1 to 0, so feeder cnt and PE count are equal in every RUN cycle.
- RUN:
  - While cnt != tlat: cnt increments; outputword is held; word_strobe=0.
  - When cnt == tlat, at the next edge:
    - cnt <= 0.
    - word_index increments, wrapping 7->0.
    - tlat is re-latched from timing.
    - If the FIFO is non-empty, the next word is popped onto outputword.
    - If the FIFO is empty, outputword <= 0 and underrun <= 1. The index still advances, because the PEs free-run.
    - word_strobe=1 in the first cycle of the new slot.
  - window_done is combinational: (state==RUN) && cnt==tlat && word_index==7.
- timing changes take effect only at slot boundaries. A value of 0 gives 1-clock slots and a strobe every cycle.
- RUN never returns to IDLE except through reset_n. Mid-operation reset discards the FIFO contents and re-primes the PEs.
- Latency:
  - A word pushed at edge E into an empty FIFO while in IDLE appears on outputword after edge E+2, at the PRIME edge.
  - In RUN, a word waits for the next slot boundary.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with in_valid=1 -> all outputs at reset values; no word accepted; pe_reset=1.
- Prime alignment: timing=4, push 0x0011 at cycle 10 -> PRIME at cycle 11, outputword=0x0011, word_strobe=1, pe_reset falls; strobes then follow every 5 cycles.
- Window: timing=2, push 16 words 0x0001..0x0010 back-to-back -> in_ready drops at level 8; word_index runs 0..7 then 0..7; window_done pulses on the cycles when the 8th and 16th words end their slots.
- Underrun: timing=3, push 2 words then stop -> 3rd slot shows outputword=0, underrun=1 and stays 1; word_index continues 2,3,...
- Timing change: timing=5, then change to 1 at mid-slot -> the current slot still lasts 6 cycles; the following slots last 2 cycles.
- Mid-run reset: pull reset_n low for 1 cycle during RUN with fifo_level=4 -> fifo_level=0, state IDLE, pe_reset=1; a fresh push re-primes with word_index=0.
